// File: rtl/dcpu_memctl.sv
// Bus slave for the dcpu core: decodes each request to block RAM, the IO window or unmapped space.
// It issues a one-cycle ack, times out IO slaves that stall, and keeps a sticky bus-error record.
module dcpu_memctl #(
  parameter int          AW        = 12,
  parameter logic [7:0]  IO_BASE   = 8'hFF,
  parameter int          TIMEOUT   = 16,
  parameter string       INIT_FILE = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  output logic        o_ack,
  output logic        o_io_cs,
  output logic        o_io_we,
  output logic [7:0]  o_io_addr,
  output logic [15:0] o_io_dat,
  input  logic [15:0] i_io_dat,
  input  logic        i_io_ack,
  output logic        o_err,
  output logic [15:0] o_err_addr
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_IO, S_ACK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   lat_addr;
  logic [15:0]   mem [2**AW];

  logic          ram_hit;
  logic          io_hit;
  logic [AW-1:0] ram_idx;

  // The compare uses 17 bits, so AW=16 still covers the whole address space.
  assign ram_hit = ({1'b0, i_addr} < 17'(2**AW));
  assign io_hit  = (i_addr[15:8] == IO_BASE);
  assign ram_idx = i_addr[AW-1:0];

  // NOTE: the RAM sits in its own reset-free process. Putting a reset on an array
  // blocks block-RAM inference, and reset is required to leave the contents intact.
  always_ff @(posedge i_clk) begin
    if (!i_reset && state == S_IDLE && i_cs && i_we && ram_hit)
      mem[ram_idx] <= i_dat;
  end

  // NOTE: all state uses non-blocking assignments. Every branch therefore sees
  // the values from before the edge, such as o_io_we in the IO completion below.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      o_ack      <= 1'b0;
      o_dat      <= '0;
      o_io_cs    <= 1'b0;
      o_io_we    <= 1'b0;
      o_io_addr  <= '0;
      o_io_dat   <= '0;
      o_err      <= 1'b0;
      o_err_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_ack <= 1'b0;
          if (i_cs) begin
            lat_addr <= i_addr;
            if (ram_hit) begin
              if (!i_we) o_dat <= mem[ram_idx];
              o_ack <= 1'b1;
              state <= S_ACK;
            end else if (io_hit) begin
              o_io_cs   <= 1'b1;
              o_io_we   <= i_we;
              o_io_addr <= i_addr[7:0];
              o_io_dat  <= i_dat;
              cnt       <= '0;
              state     <= S_IO;
            end else begin
              // Unmapped: a write is dropped and a read returns zero.
              o_dat      <= '0;
              o_err      <= 1'b1;
              o_err_addr <= i_addr;
              o_ack      <= 1'b1;
              state      <= S_ACK;
            end
          end
        end

        S_IO: begin
          // A slave ack wins over a timeout that lands in the same cycle.
          if (i_io_ack) begin
            o_dat   <= o_io_we ? 16'h0000 : i_io_dat;
            o_io_cs <= 1'b0;
            o_io_we <= 1'b0;
            o_ack   <= 1'b1;
            state   <= S_ACK;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            o_dat      <= 16'hFFFF;
            o_err      <= 1'b1;
            o_err_addr <= lat_addr;
            o_io_cs    <= 1'b0;
            o_io_we    <= 1'b0;
            o_ack      <= 1'b1;
            state      <= S_ACK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_ACK: begin
          o_ack <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu_memctl.sv
// Directed-vector bench for dcpu_memctl. Expectations go into a scoreboard queue,
// and a negedge monitor checks each o_ack pulse against the front entry.
module tb_dcpu_memctl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cs = 1'b0;
  logic        i_we = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_dat = '0;
  logic [15:0] o_dat;
  logic        o_ack;
  logic        o_io_cs;
  logic        o_io_we;
  logic [7:0]  o_io_addr;
  logic [15:0] o_io_dat;
  logic [15:0] i_io_dat = '0;
  logic        i_io_ack = 1'b0;
  logic        o_err;
  logic [15:0] o_err_addr;

  dcpu_memctl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(i_cs), .i_we(i_we),
    .i_addr(i_addr), .i_dat(i_dat), .o_dat(o_dat), .o_ack(o_ack),
    .o_io_cs(o_io_cs), .o_io_we(o_io_we), .o_io_addr(o_io_addr),
    .o_io_dat(o_io_dat), .i_io_dat(i_io_dat), .i_io_ack(i_io_ack),
    .o_err(o_err), .o_err_addr(o_err_addr)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        chk_dat;
    logic [15:0] dat;
    logic        err;
    logic [15:0] err_addr;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (!i_reset && o_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(o_ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
        if (e.chk_dat) check({e.name, "_dat"}, 32'(o_dat), 32'(e.dat));
        check({e.name, "_err"}, 32'(o_err), 32'(e.err));
        check({e.name, "_err_addr"}, 32'(o_err_addr), 32'(e.err_addr));
      end
    end
  end

  // Issue one request. The caller is at a negedge. io_d >= 1 raises i_io_ack
  // at negedge d+io_d, and lat is the hand-computed ack delay in cycles.
  task automatic req(input string name, input logic [15:0] addr, input logic we,
                     input logic [15:0] wdat, input int io_d, input logic [15:0] io_rdat,
                     input bit hold, input bit drop, input int lat, input bit chk_dat,
                     input logic [15:0] edat, input logic eerr, input logic [15:0] eea);
    exp_t e;
    int   d;
    bit   seen_io, got;
    i_cs = 1'b1; i_we = we; i_addr = addr; i_dat = wdat;
    d = cyc;
    e.name = name; e.chk_dat = chk_dat; e.dat = edat; e.err = eerr;
    e.err_addr = eea; e.cyc = d + lat;
    sb.push_back(e);
    seen_io = 1'b0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge i_clk);
      i_io_ack = 1'b0;
      if (o_io_cs && !seen_io) begin
        seen_io = 1'b1;
        check({name, "_io_addr"}, 32'(o_io_addr), 32'(addr[7:0]));
        check({name, "_io_we"}, 32'(o_io_we), 32'(we));
        if (we) check({name, "_io_dat"}, 32'(o_io_dat), 32'(wdat));
        if (drop) i_cs = 1'b0;
      end
      if (o_ack) got = 1'b1;
      else if (io_d >= 1 && cyc == d + io_d) begin
        i_io_ack = 1'b1;
        i_io_dat = io_rdat;
      end
    end
    if (!got) check({name, "_ack_timeout"}, 32'd0, 32'd1);
    if (!hold) begin
      i_cs = 1'b0;
      @(negedge i_clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_dat", 32'(o_dat), 32'd0);
    check("rst_io_cs", 32'(o_io_cs), 32'd0);
    check("rst_io_we", 32'(o_io_we), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_err_addr", 32'(o_err_addr), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    //  name        addr      we    wdat      io_d io_rdat  hold drop lat chk  edat      err   ea
    req("wr_0010",  16'h0010, 1'b1, 16'hBEEF, -1,  16'h0,   0,   0,   1,  0,   16'h0000, 1'b0, 16'h0000);
    req("rd_0010",  16'h0010, 1'b0, 16'h0000, -1,  16'h0,   0,   0,   1,  1,   16'hBEEF, 1'b0, 16'h0000);
    req("wr_0000",  16'h0000, 1'b1, 16'h1111, -1,  16'h0,   0,   0,   1,  0,   16'h0000, 1'b0, 16'h0000);
    req("wr_0001",  16'h0001, 1'b1, 16'h2222, -1,  16'h0,   0,   0,   1,  0,   16'h0000, 1'b0, 16'h0000);
    req("wr_0fff",  16'h0FFF, 1'b1, 16'hA5A5, -1,  16'h0,   0,   0,   1,  0,   16'h0000, 1'b0, 16'h0000);
    req("rd_0fff",  16'h0FFF, 1'b0, 16'h0000, -1,  16'h0,   0,   0,   1,  1,   16'hA5A5, 1'b0, 16'h0000);
    // Held cs: the second request is decoded in the IDLE cycle after ACK, 2 cycles later.
    req("fetch_0",  16'h0000, 1'b0, 16'h0000, -1,  16'h0,   1,   0,   1,  1,   16'h1111, 1'b0, 16'h0000);
    req("exec_1",   16'h0001, 1'b0, 16'h0000, -1,  16'h0,   0,   0,   2,  1,   16'h2222, 1'b0, 16'h0000);
    req("io_rd05",  16'hFF05, 1'b0, 16'h0000, 3,   16'h1234, 0,  0,   4,  1,   16'h1234, 1'b0, 16'h0000);
    req("io_wr02",  16'hFF02, 1'b1, 16'h5555, 1,   16'hABCD, 0,  0,   2,  1,   16'h0000, 1'b0, 16'h0000);
    // The slave ack lands on the timeout cycle, so the ack wins and no error is recorded.
    req("io_race",  16'hFF07, 1'b0, 16'h0000, 16,  16'h7777, 0,  0,   17, 1,   16'h7777, 1'b0, 16'h0000);
    req("io_drop",  16'hFF09, 1'b0, 16'h0000, 2,   16'h0042, 0,  1,   3,  1,   16'h0042, 1'b0, 16'h0000);
    req("io_tmo",   16'hFF01, 1'b1, 16'h9999, -1,  16'h0,   0,   0,   17, 1,   16'hFFFF, 1'b1, 16'hFF01);
    req("unmap8k",  16'h8000, 1'b0, 16'h0000, -1,  16'h0,   0,   0,   1,  1,   16'h0000, 1'b1, 16'h8000);
    req("unmap1k",  16'h1000, 1'b0, 16'h0000, -1,  16'h0,   0,   0,   1,  1,   16'h0000, 1'b1, 16'h1000);

    // Reset during an IO transaction: abort with no ack, and the error flag clears.
    i_cs = 1'b1; i_we = 1'b0; i_addr = 16'hFF05;
    repeat (2) @(negedge i_clk);
    check("pre_rst_io_cs", 32'(o_io_cs), 32'd1);
    i_reset = 1'b1; i_cs = 1'b0;
    @(negedge i_clk);
    check("mid_rst_io_cs", 32'(o_io_cs), 32'd0);
    check("mid_rst_ack", 32'(o_ack), 32'd0);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);
    check("post_rst_io_cs", 32'(o_io_cs), 32'd0);
    check("post_rst_err", 32'(o_err), 32'd0);
    check("post_rst_err_addr", 32'(o_err_addr), 32'd0);

    // RAM contents survive reset.
    req("rd_keep",  16'h0010, 1'b0, 16'h0000, -1,  16'h0,   0,   0,   1,  1,   16'hBEEF, 1'b0, 16'h0000);

    repeat (3) @(negedge i_clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
